shift_subtract_divider: RTL and testbench

Sequential restoring (shift-subtract) unsigned divider. It is the inverse operation of the add-shift multiplier and uses the same start/ready handshake and the same operand/result port style. It takes a WIDTH-bit dividend and divisor and produces the quotient and remainder one bit per clock. It sits beside the multiplier in the arithmetic datapath and is driven by the same controller/testbench style.

---
 rtl/shift_subtract_divider.sv | 144 ++++++++++++++
 tb/tb_shift_subtract_divider.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/shift_subtract_divider.sv
// shift_subtract_divider
//   Sequential restoring (shift-subtract) unsigned divider. One quotient bit is
//   produced per clock. It shares the start/ready handshake of the add-shift
//   multiplier.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-high; clears all state
//   start        request pulse, sampled only while ready=1
//   a_in         dividend, latched on an accepted start
//   b_in         divisor, latched on an accepted start
//   q            quotient, registered, held until the next accepted start
//   rem          remainder, registered, held until the next accepted start
//   ready        1 = idle, results valid, a new start will be accepted
//   div_by_zero  1 = last operation had divisor 0; held with the results
module shift_subtract_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rem,
    output logic             ready,
    output logic             div_by_zero
);

    localparam int unsigned    CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDz
    } state_t;

    state_t           r_state,    w_state_next;
    logic [WIDTH-1:0] r_dividend, w_dividend_next;
    logic [WIDTH-1:0] r_divisor,  w_divisor_next;
    logic [WIDTH-1:0] r_p,        w_p_next;
    logic [WIDTH-1:0] r_quot,     w_quot_next;
    logic [CW-1:0]    r_count,    w_count_next;
    logic [WIDTH-1:0] r_q,        w_q_next;
    logic [WIDTH-1:0] r_rem,      w_rem_next;
    logic             r_dz,       w_dz_next;

    // The partial remainder shifted left with the next dividend bit needs
    // WIDTH+1 bits, otherwise the carry out of P is lost when the divisor MSB
    // is set (e.g. 0xFF / 0x80).
    logic [WIDTH:0]   w_t;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_p_new;
    logic [WIDTH-1:0] w_quot_new;

    assign w_t        = {r_p, r_dividend[WIDTH-1]};
    assign w_ge       = (w_t >= {1'b0, r_divisor});
    // When w_ge holds the true difference is below the divisor, so the low
    // WIDTH bits of the subtraction are exact.
    assign w_diff     = w_t[WIDTH-1:0] - r_divisor;
    assign w_p_new    = w_ge ? w_diff : w_t[WIDTH-1:0];
    assign w_quot_new = {r_quot[WIDTH-2:0], w_ge};

    always_comb begin
        w_state_next    = r_state;
        w_dividend_next = r_dividend;
        w_divisor_next  = r_divisor;
        w_p_next        = r_p;
        w_quot_next     = r_quot;
        w_count_next    = r_count;
        w_q_next        = r_q;
        w_rem_next      = r_rem;
        w_dz_next       = r_dz;

        unique case (r_state)
            StIdle: begin
                if (start) begin
                    // Operands are latched even for a zero divisor: the DZ
                    // result reports the dividend as the remainder.
                    w_dividend_next = a_in;
                    w_divisor_next  = b_in;
                    w_p_next        = '0;
                    w_quot_next     = '0;
                    w_count_next    = CNT_INIT;
                    w_state_next    = (b_in == '0) ? StDz : StRun;
                end
            end
            StRun: begin
                w_dividend_next = {r_dividend[WIDTH-2:0], 1'b0};
                w_p_next        = w_p_new;
                w_quot_next     = w_quot_new;
                w_count_next    = r_count - CNT_ONE;
                if (r_count == CNT_ONE) begin
                    w_q_next     = w_quot_new;
                    w_rem_next   = w_p_new;
                    w_dz_next    = 1'b0;
                    w_state_next = StIdle;
                end
            end
            StDz: begin
                w_q_next     = '1;
                w_rem_next   = r_dividend;
                w_dz_next    = 1'b1;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_p        <= '0;
            r_quot     <= '0;
            r_count    <= '0;
            r_q        <= '0;
            r_rem      <= '0;
            r_dz       <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_dividend <= w_dividend_next;
            r_divisor  <= w_divisor_next;
            r_p        <= w_p_next;
            r_quot     <= w_quot_next;
            r_count    <= w_count_next;
            r_q        <= w_q_next;
            r_rem      <= w_rem_next;
            r_dz       <= w_dz_next;
        end
    end

    assign q           = r_q;
    assign rem         = r_rem;
    assign div_by_zero = r_dz;
    assign ready       = (r_state == StIdle);

endmodule

// File: tb/tb_shift_subtract_divider.sv
// tb_shift_subtract_divider
//   Directed and sweep checks for shift_subtract_divider (WIDTH=8).
//   Inputs are driven on the falling edge; outputs are sampled on the falling
//   edge, away from the active rising edge.
module tb_shift_subtract_divider;

    logic       clock;
    logic       reset;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic [7:0] q;
    logic [7:0] rem;
    logic       ready;
    logic       div_by_zero;

    int n_checks;
    int n_fail;

    shift_subtract_divider #(
        .WIDTH(8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .a_in        (a_in),
        .b_in        (b_in),
        .q           (q),
        .rem         (rem),
        .ready       (ready),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at the first falling edge after an accepted start; counts the
    // falling edges that see ready low, bounded so a stuck DUT cannot hang.
    task automatic wait_ready(output int lat);
        lat = 0;
        while (ready !== 1'b1 && lat < 30) begin
            lat++;
            @(negedge clock);
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er, input logic edz,
                          input int elat);
        int lat;
        @(negedge clock);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_ready(lat);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_q"}, {24'd0, q}, {24'd0, eq});
        check({tag, "_rem"}, {24'd0, rem}, {24'd0, er});
        check({tag, "_dz"}, {31'd0, div_by_zero}, {31'd0, edz});
    endtask

    initial begin
        int lat;
        int sp;
        logic [7:0] pa;
        logic [7:0] pb;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        a_in     = '0;
        b_in     = '0;

        // Reset state.
        @(negedge clock);
        @(negedge clock);
        check("rst_q", {24'd0, q}, 32'h0);
        check("rst_rem", {24'd0, rem}, 32'h0);
        check("rst_ready", {31'd0, ready}, 32'h1);
        check("rst_dz", {31'd0, div_by_zero}, 32'h0);
        reset = 1'b0;

        // Directed divisions.
        run_op("d3_04", 8'hD3, 8'h04, 8'h34, 8'h03, 1'b0, 8);
        run_op("07_09", 8'h07, 8'h09, 8'h00, 8'h07, 1'b0, 8);
        run_op("ff_01", 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 8);
        run_op("ff_ff", 8'hFF, 8'hFF, 8'h01, 8'h00, 1'b0, 8);
        run_op("ff_80", 8'hFF, 8'h80, 8'h01, 8'h7F, 1'b0, 8);
        // Divide by zero, then a normal op clears the flag.
        run_op("2a_00", 8'h2A, 8'h00, 8'hFF, 8'h2A, 1'b1, 1);
        run_op("0c_04", 8'h0C, 8'h04, 8'h03, 8'h00, 1'b0, 8);

        // Start during RUN is ignored; outputs hold the old result meanwhile.
        @(negedge clock);
        a_in  = 8'hD3;
        b_in  = 8'h04;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        a_in  = 8'h10;
        b_in  = 8'h02;
        start = 1'b1;
        check("ign_busy", {31'd0, ready}, 32'h0);
        check("ign_hold_q", {24'd0, q}, 32'h03);
        @(negedge clock);
        start = 1'b0;
        wait_ready(lat);
        check("ign_lat", lat + 3, 8);
        check("ign_q", {24'd0, q}, 32'h34);
        check("ign_rem", {24'd0, rem}, 32'h03);

        // Asynchronous reset in the middle of RUN.
        @(negedge clock);
        a_in  = 8'hD3;
        b_in  = 8'h04;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("arst_q", {24'd0, q}, 32'h0);
        check("arst_rem", {24'd0, rem}, 32'h0);
        check("arst_ready", {31'd0, ready}, 32'h1);
        check("arst_dz", {31'd0, div_by_zero}, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        run_op("64_07", 8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 8);

        // Sweep with start held high: check the division identity and the
        // WIDTH+1 spacing between ready pulses.
        @(negedge clock);
        pa    = 8'($urandom_range(0, 255));
        pb    = 8'($urandom_range(1, 255));
        a_in  = pa;
        b_in  = pb;
        start = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            sp = 0;
            do begin
                @(negedge clock);
                sp++;
            end while (ready !== 1'b1 && sp < 30);
            check("sweep_spacing", sp, 9);
            check("sweep_identity", (32'(q) * 32'(pb)) + 32'(rem), 32'(pa));
            check("sweep_rem_lt_b", {31'd0, (rem < pb)}, 32'h1);
            pa   = 8'($urandom_range(0, 255));
            pb   = 8'($urandom_range(1, 255));
            a_in = pa;
            b_in = pb;
        end
        start = 1'b0;
        @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
